// File: rtl/snn_pkg.sv
// snn_pkg
//   Shared definitions for the spiking-network datapath blocks
//   (spike_rx_buffer, event_control).
//   SPK_W_DEF : default spike vector width (one bit per pre-synaptic neuron)
//   DEPTH_DEF : default receive FIFO depth
//   TS_W_DEF  : default time-step counter width
//   spk_vec_t : spike vector at the default width
package snn_pkg;

  localparam int unsigned SPK_W_DEF = 32;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned TS_W_DEF  = 8;

  typedef logic [SPK_W_DEF-1:0] spk_vec_t;

endpackage

// File: rtl/spk_popcnt.sv
// spk_popcnt
//   Combinational population count of a spike vector.
//   Ports:
//     vec : input  [W-1:0]           spike vector
//     cnt : output [$clog2(W+1)-1:0] number of set bits in vec
module spk_popcnt #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0]           vec,
  output logic [$clog2(W+1)-1:0] cnt
);

  localparam int unsigned CNT_W = $clog2(W + 1);

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < W; i++) begin
      cnt = cnt + CNT_W'(vec[i]);
    end
  end

endmodule

// File: rtl/spike_rx_buffer.sv
// spike_rx_buffer
//   Receive FIFO between an upstream layer's post-synaptic buffer and the
//   local event controller. Counts consumed vectors as time steps and keeps
//   a sticky overflow flag for vectors offered while full.
//   Optional feature: define SPK_RX_STATS_EN to add spk_total, a saturating
//   16-bit sum of the set bits of every accepted vector.
//   Ports:
//     clk             : input              clock, rising edge
//     rst             : input              asynchronous active-high reset
//     spk_in          : input  [SPK_W-1:0] incoming spike vector
//     spk_in_valid    : input              upstream offers spk_in
//     post_synp_avail : output             buffer can accept a vector
//     pre_synpt_spk   : output [SPK_W-1:0] head vector (0 when empty)
//     spk_vld         : output             head vector valid
//     spk_ack         : input              consumer takes the head vector
//     time_step       : output [TS_W-1:0]  vectors consumed (wraps)
//     spk_total       : output [15:0]      popcount sum (SPK_RX_STATS_EN only)
//     ovf             : output             sticky: offer while full
module spike_rx_buffer
  import snn_pkg::*;
#(
  parameter int unsigned SPK_W = SPK_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned TS_W  = TS_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SPK_W-1:0] spk_in,
  input  logic             spk_in_valid,
  output logic             post_synp_avail,
  output logic [SPK_W-1:0] pre_synpt_spk,
  output logic             spk_vld,
  input  logic             spk_ack,
  output logic [TS_W-1:0]  time_step,
`ifdef SPK_RX_STATS_EN
  output logic [15:0]      spk_total,
`endif
  output logic             ovf
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [SPK_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             wr_en;
  logic             rd_en;

  // Status is decoded from the registered count only, so spk_ack never
  // reaches post_synp_avail combinationally.
  assign post_synp_avail = (count < CNT_W'(DEPTH));
  assign spk_vld         = (count != '0);
  assign pre_synpt_spk   = spk_vld ? mem[rd_ptr] : '0;

  assign wr_en = spk_in_valid && post_synp_avail;
  assign rd_en = spk_ack && spk_vld;

  // Storage carries no reset; the zero-on-empty mux hides stale entries.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= spk_in;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      time_step <= '0;
      ovf       <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        time_step <= time_step + TS_W'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (spk_in_valid && !post_synp_avail) begin
        ovf <= 1'b1;
      end
    end
  end

`ifdef SPK_RX_STATS_EN
  localparam int unsigned POP_W = $clog2(SPK_W + 1);

  logic [POP_W-1:0] pop;
  logic [16:0]      total_sum;

  spk_popcnt #(
    .W(SPK_W)
  ) u_popcnt (
    .vec(spk_in),
    .cnt(pop)
  );

  // One spare bit catches the carry that triggers saturation.
  assign total_sum = {1'b0, spk_total} + 17'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spk_total <= '0;
    end else if (wr_en) begin
      spk_total <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_spike_rx_buffer.sv
// tb_spike_rx_buffer
//   Self-checking bench for spike_rx_buffer (SPK_W=32, DEPTH=4, TS_W=8).
//   A fixed vector table covers the basic, full and overflow cases; the
//   remaining sequences and random traffic are checked against a
//   queue-based reference model. Build with SPK_RX_STATS_EN defined to
//   include the spk_total checks.
module tb_spike_rx_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] spk_in = '0;
  logic        spk_in_valid = 1'b0;
  logic        post_synp_avail;
  logic [31:0] pre_synpt_spk;
  logic        spk_vld;
  logic        spk_ack = 1'b0;
  logic [7:0]  time_step;
  logic        ovf;
`ifdef SPK_RX_STATS_EN
  logic [15:0] spk_total;
`endif

  int errors = 0;
  int checks = 0;

  spike_rx_buffer #(
    .SPK_W(32),
    .DEPTH(DEPTH),
    .TS_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .spk_in(spk_in),
    .spk_in_valid(spk_in_valid),
    .post_synp_avail(post_synp_avail),
    .pre_synpt_spk(pre_synpt_spk),
    .spk_vld(spk_vld),
    .spk_ack(spk_ack),
    .time_step(time_step),
`ifdef SPK_RX_STATS_EN
    .spk_total(spk_total),
`endif
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  // Reference model: the FIFO contents as a queue.
  logic [31:0] mq[$];
  logic [7:0]  m_ts;
  bit          m_ovf;
  int          m_total;

  task automatic model_reset();
    mq.delete();
    m_ts    = '0;
    m_ovf   = 1'b0;
    m_total = 0;
  endtask

  task automatic model_step(input bit v, input logic [31:0] d, input bit a);
    bit rd;
    bit wr;
    rd = a && (mq.size() != 0);
    wr = v && (mq.size() < DEPTH);
    if (v && !wr) m_ovf = 1'b1;
    if (rd) begin
      void'(mq.pop_front());
      m_ts = m_ts + 8'd1;
    end
    if (wr) begin
      mq.push_back(d);
      m_total = m_total + $countones(d);
      if (m_total > 65535) m_total = 65535;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".spk_vld"}, 64'(spk_vld), 64'(mq.size() != 0));
    chk({tag, ".avail"}, 64'(post_synp_avail), 64'(mq.size() < DEPTH));
    chk({tag, ".spk"}, 64'(pre_synpt_spk), (mq.size() != 0) ? 64'(mq[0]) : 64'd0);
    chk({tag, ".time_step"}, 64'(time_step), 64'(m_ts));
    chk({tag, ".ovf"}, 64'(ovf), 64'(m_ovf));
`ifdef SPK_RX_STATS_EN
    chk({tag, ".spk_total"}, 64'(spk_total), 64'(m_total));
`endif
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic cycle(input bit v, input logic [31:0] d, input bit a);
    spk_in_valid = v;
    spk_in       = d;
    spk_ack      = a;
    @(posedge clk);
    #1;
    spk_in_valid = 1'b0;
    spk_ack      = 1'b0;
    spk_in       = '0;
  endtask

  task automatic mcycle(input bit v, input logic [31:0] d, input bit a, input string tag);
    cycle(v, d, a);
    model_step(v, d, a);
    check_model(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_model("reset");
  endtask

  typedef struct {
    bit          v;
    logic [31:0] d;
    bit          a;
    bit          e_vld;
    bit          e_av;
    logic [31:0] e_spk;
    logic [7:0]  e_ts;
    bit          e_ovf;
  } vec_t;

  vec_t tbl[20];

  initial begin
    logic [31:0] a1, a2, a3, a4, a5, b1, b2, b3, b4, b5;
    a1 = 32'hA000_0001; a2 = 32'h0000_0000; a3 = 32'hA000_0003;
    a4 = 32'hA000_0004; a5 = 32'hA5A5_A5A5;
    b1 = 32'hB000_0001; b2 = 32'hB000_0002; b3 = 32'hB000_0003;
    b4 = 32'hB000_0004; b5 = 32'hB5B5_B5B5;

    //          v  d             a  vld av spk           ts  ovf
    tbl[0]  = '{1, 32'h9038_4112, 0, 1, 1, 32'h9038_4112, 0, 0};
    tbl[1]  = '{0, 32'h0,         1, 0, 1, 32'h0,         1, 0};
    tbl[2]  = '{0, 32'h0,         1, 0, 1, 32'h0,         1, 0};
    tbl[3]  = '{1, a1,            0, 1, 1, a1,            1, 0};
    tbl[4]  = '{1, a2,            0, 1, 1, a1,            1, 0};
    tbl[5]  = '{1, a3,            0, 1, 1, a1,            1, 0};
    tbl[6]  = '{1, a4,            0, 1, 0, a1,            1, 0};
    tbl[7]  = '{1, a5,            0, 1, 0, a1,            1, 1};
    tbl[8]  = '{0, 32'h0,         1, 1, 1, a2,            2, 1};
    tbl[9]  = '{0, 32'h0,         1, 1, 1, a3,            3, 1};
    tbl[10] = '{0, 32'h0,         1, 1, 1, a4,            4, 1};
    tbl[11] = '{0, 32'h0,         1, 0, 1, 32'h0,         5, 1};
    tbl[12] = '{1, b1,            0, 1, 1, b1,            5, 1};
    tbl[13] = '{1, b2,            0, 1, 1, b1,            5, 1};
    tbl[14] = '{1, b3,            0, 1, 1, b1,            5, 1};
    tbl[15] = '{1, b4,            0, 1, 0, b1,            5, 1};
    tbl[16] = '{1, b5,            1, 1, 1, b2,            6, 1};
    tbl[17] = '{0, 32'h0,         1, 1, 1, b3,            7, 1};
    tbl[18] = '{0, 32'h0,         1, 1, 1, b4,            8, 1};
    tbl[19] = '{0, 32'h0,         1, 0, 1, 32'h0,         9, 1};

    #3;
    do_reset();

    // Table: single write/ack, fill + overflow + drain, full with read+write.
    for (int i = 0; i < 20; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].a);
      chk($sformatf("tbl%0d.spk_vld", i), 64'(spk_vld), 64'(tbl[i].e_vld));
      chk($sformatf("tbl%0d.avail", i), 64'(post_synp_avail), 64'(tbl[i].e_av));
      chk($sformatf("tbl%0d.spk", i), 64'(pre_synpt_spk), 64'(tbl[i].e_spk));
      chk($sformatf("tbl%0d.time_step", i), 64'(time_step), 64'(tbl[i].e_ts));
      chk($sformatf("tbl%0d.ovf", i), 64'(ovf), 64'(tbl[i].e_ovf));
    end

    // Steady occupancy of two with write+ack every cycle; pointers wrap.
    do_reset();
    mcycle(1, 32'hC000_0000, 0, "occ2.fill0");
    mcycle(1, 32'hC000_0001, 0, "occ2.fill1");
    for (int i = 0; i < 10; i++) begin
      mcycle(1, 32'hC000_0002 + 32'(i), 1, $sformatf("occ2.%0d", i));
      chk($sformatf("occ2.%0d.depth", i), 64'(mq.size()), 64'd2);
    end

    // 256 write/ack pairs: time_step returns to 0.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      mcycle(1, $urandom, 0, $sformatf("ts.w%0d", i));
      mcycle(0, 32'h0, 1, $sformatf("ts.a%0d", i));
    end
    chk("ts.wrap", 64'(time_step), 64'd0);

    // Reset between clock edges with three entries held.
    do_reset();
    mcycle(1, 32'hD000_0000, 0, "arst.w0");
    mcycle(1, 32'hD000_0001, 1, "arst.w1");
    mcycle(1, 32'hD000_0002, 0, "arst.w2");
    mcycle(1, 32'hD000_0003, 0, "arst.w3");
    #3;
    rst = 1'b1;
    #1;
    chk("arst.spk_vld", 64'(spk_vld), 64'd0);
    chk("arst.avail", 64'(post_synp_avail), 64'd1);
    chk("arst.spk", 64'(pre_synpt_spk), 64'd0);
    chk("arst.time_step", 64'(time_step), 64'd0);
    chk("arst.ovf", 64'(ovf), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    mcycle(1, 32'hE123_4567, 0, "arst.post");

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      mcycle(bit'($urandom_range(0, 2) != 0), $urandom,
             bit'($urandom_range(0, 2) != 0), $sformatf("rnd%0d", i));
    end

`ifdef SPK_RX_STATS_EN
    // All-ones vector accepted 2048 times: the sum saturates.
    do_reset();
    mcycle(1, 32'hFFFF_FFFF, 0, "sat.first");
    for (int i = 1; i < 2048; i++) begin
      mcycle(1, 32'hFFFF_FFFF, 1, $sformatf("sat%0d", i));
    end
    chk("sat.final", 64'(spk_total), 64'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
